// File: rtl/alu_pipe.sv
// alu_pipe - two-stage pipelined ALU with valid/ready handshakes on both sides.
//
// Stage 1 captures the function code and operands on an input transfer.
// Stage 2 computes from the stage-1 registers and registers the result and flags.
// Result, flags and op_count all come straight from flops. in_ready is the only
// combinational output, and it depends only on pipeline state and out_ready.
//
// Optional feature macro: ALU_XOR_EN
//   defined   -> ALU_XOR computes a ^ b (C = V = 0)
//   undefined -> ALU_XOR is treated as an unsupported code (result 0, flag_err = 1)
//
// Parameters:
//   DWIDTH  operand/result width (>= 2)
//   CWIDTH  completed-operation counter width
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   alu_func, alu_a/b     function code and operands
//   out_valid / out_ready output handshake
//   alu_out               result
//   flag_z/n/c/v/err      zero, negative, carry, signed overflow, unsupported code
//   op_count              results transferred out since reset (wraps)

`ifndef ALU_ADD
`define ALU_ADD  3'd0
`define ALU_SUB  3'd1
`define ALU_ADDI 3'd2
`define ALU_AND  3'd3
`define ALU_ANDI 3'd4
`define ALU_OR   3'd5
`define ALU_XOR  3'd6
`endif

module alu_pipe #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_func,
    input  logic [DWIDTH-1:0] alu_a,
    input  logic [DWIDTH-1:0] alu_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] alu_out,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_err,
    output logic [CWIDTH-1:0] op_count
);

    localparam int MSB = DWIDTH - 1;

    logic              r_s1_valid;
    logic [2:0]        r_s1_func;
    logic [DWIDTH-1:0] r_s1_a;
    logic [DWIDTH-1:0] r_s1_b;

    logic              r_s2_valid;
    logic [DWIDTH-1:0] r_out;
    logic              r_z;
    logic              r_n;
    logic              r_c;
    logic              r_v;
    logic              r_err;
    logic [CWIDTH-1:0] r_count;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [DWIDTH:0]   w_sum;
    logic [DWIDTH:0]   w_diff;
    logic [DWIDTH-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_err;
    logic              w_z;
    logic              w_n;

    // A stage may load when it is empty or when its content is leaving downstream.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Extra top bit carries the carry-out; subtraction is a + ~b + 1 so C=1 means no borrow.
    assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_diff = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{DWIDTH{1'b0}}, 1'b1};

    // Function decode: result, carry, overflow and unsupported-code detection.
    always_comb begin
        w_res = {DWIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (r_s1_func)
            `ALU_ADD, `ALU_ADDI: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[DWIDTH];
                w_v   = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
            end
            `ALU_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[DWIDTH];
                w_v   = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
            end
            `ALU_AND, `ALU_ANDI: begin
                w_res = r_s1_a & r_s1_b;
            end
            `ALU_OR: begin
                w_res = r_s1_a | r_s1_b;
            end
`ifdef ALU_XOR_EN
            `ALU_XOR: begin
                w_res = r_s1_a ^ r_s1_b;
            end
`endif
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Zero/negative flags; an unsupported code reports a zero result.
    always_comb begin
        w_z = 1'b0;
        w_n = 1'b0;
        if (w_err) begin
            w_z = 1'b1;
            w_n = 1'b0;
        end else begin
            w_z = (w_res == {DWIDTH{1'b0}});
            w_n = w_res[MSB];
        end
    end

    // Stage 1: capture an operation on an input transfer, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_func  <= 3'd0;
            r_s1_a     <= {DWIDTH{1'b0}};
            r_s1_b     <= {DWIDTH{1'b0}};
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_func <= alu_func;
                r_s1_a    <= alu_a;
                r_s1_b    <= alu_b;
            end
        end
    end

    // Stage 2: register result and flags; held unchanged while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out      <= {DWIDTH{1'b0}};
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_res;
                r_z   <= w_z;
                r_n   <= w_n;
                r_c   <= w_c;
                r_v   <= w_v;
                r_err <= w_err;
            end
        end
    end

    // Completed-operation counter; wraps naturally at 2^CWIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CWIDTH{1'b0}};
        end else if (r_s2_valid && out_ready) begin
            r_count <= r_count + {{(CWIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = r_s2_valid;
    assign alu_out   = r_out;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign flag_err  = r_err;
    assign op_count  = r_count;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe - directed self-checking bench for alu_pipe (DWIDTH=16, CWIDTH=4
// so that counter wrap is reached with a short run).

`ifndef ALU_ADD
`define ALU_ADD  3'd0
`define ALU_SUB  3'd1
`define ALU_ADDI 3'd2
`define ALU_AND  3'd3
`define ALU_ANDI 3'd4
`define ALU_OR   3'd5
`define ALU_XOR  3'd6
`endif

module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_func;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        flag_v;
    logic        flag_err;
    logic [3:0]  op_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  exp_count;

    alu_pipe #(.DWIDTH(16), .CWIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_func  (alu_func),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_err  (flag_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] r,
                           input logic z, input logic n, input logic c,
                           input logic v, input logic e);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".out"}, {16'd0, alu_out}, {16'd0, r});
        chk({tag, ".flags_zncve"}, {27'd0, flag_z, flag_n, flag_c, flag_v, flag_err},
            {27'd0, z, n, c, v, e});
    endtask

    task automatic present(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        alu_func = f;
        alu_a    = a;
        alu_b    = b;
        in_valid = 1'b1;
    endtask

    // One isolated op with out_ready=1: result after the second edge, counted after the third.
    task automatic run_single(input string tag, input logic [2:0] f,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input logic z, input logic n,
                              input logic c, input logic v, input logic e);
        present(f, a, b);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".latency"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk_res(tag, r, z, n, c, v, e);
        @(negedge clk);
        exp_count = exp_count + 4'd1;
        chk({tag, ".count"}, {28'd0, op_count}, {28'd0, exp_count});
        chk({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_func  = 3'd0;
        alu_a     = 16'h0000;
        alu_b     = 16'h0000;
        exp_count = 4'd0;

        // Reset state
        #2;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.alu_out", {16'd0, alu_out}, 32'd0);
        chk("rst.flags", {27'd0, flag_z, flag_n, flag_c, flag_v, flag_err}, 32'd0);
        chk("rst.count", {28'd0, op_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Isolated arithmetic, boundary flag cases
        run_single("add_ovf", `ALU_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_single("sub_brw", `ALU_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_single("sub_eq",  `ALU_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_single("sub_ovf", `ALU_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_single("addi_c",  `ALU_ADDI, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back: 8 ops, one result per cycle, in order
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 8) begin
                present(`ALU_ADD, 16'(cyc * 4369), 16'h0101);
                chk("b2b.in_ready", {31'd0, in_ready}, 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 1 && cyc <= 8) begin
                chk("b2b.valid", {31'd0, out_valid}, 32'd1);
                chk("b2b.data", {16'd0, alu_out}, 32'((cyc - 1) * 4369 + 257));
            end else begin
                chk("b2b.idle", {31'd0, out_valid}, 32'd0);
            end
        end
        exp_count = exp_count + 4'd8;
        chk("b2b.count", {28'd0, op_count}, {28'd0, exp_count});

        // Backpressure: two ops fill the pipe, third stalls, outputs hold
        out_ready = 1'b0;
        present(`ALU_OR, 16'h00F0, 16'h0F00);
        chk("bp.rdy0", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        present(`ALU_AND, 16'hFF0F, 16'h0FFF);
        chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        present(`ALU_ANDI, 16'h1234, 16'h00FF);
        chk("bp.full", {31'd0, in_ready}, 32'd0);
        chk_res("bp.hold0", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("bp.stall_rdy", {31'd0, in_ready}, 32'd0);
            chk_res("bp.hold", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_res("bp.second", 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_res("bp.third", 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp.drained", {31'd0, out_valid}, 32'd0);
        exp_count = exp_count + 4'd3;
        chk("bp.count", {28'd0, op_count}, {28'd0, exp_count});

        // Optional XOR and an unsupported code
`ifdef ALU_XOR_EN
        run_single("xor", `ALU_XOR, 16'hF0F0, 16'hFF00, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        run_single("xor", `ALU_XOR, 16'hF0F0, 16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        run_single("badop", 3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset with two ops in flight
        out_ready = 1'b0;
        present(`ALU_ADD, 16'h0001, 16'h0001);
        @(negedge clk);
        present(`ALU_ADD, 16'h0002, 16'h0002);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid.full", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid.count", {28'd0, op_count}, 32'd0);
        chk("mid.in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid.alu_out", {16'd0, alu_out}, 32'd0);
        exp_count = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("mid.no_stale", {31'd0, out_valid}, 32'd0);
        end
        run_single("post_rst", `ALU_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
